// File: rtl/ram_master_pkg.sv
// Shared encodings for the RAM initiator: access sizes, FSM states and the alignment rule.
package ram_master_pkg;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRd    = 3'd1,
    StCapt  = 3'd2,
    StWr    = 3'd3,
    StFault = 3'd4
  } state_e;

  // Size 2'b11 behaves as a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SzByte:  return 1'b0;
      SzHalf:  return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ram_master_mem_lane.sv
// Big-endian byte/half lane extraction for loads and lane merge for sub-word stores.
module mem_lane
  import ram_master_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Offset 0 is the most significant lane.
  assign byte_sh = {~off_i, 3'b000};
  assign half_sh = {~off_i[1], 4'b0000};
  assign byte_v  = word_i[byte_sh +: 8];
  assign half_v  = word_i[half_sh +: 16];

  always_comb begin
    load_o   = word_i;
    merged_o = wdata_i;
    case (size_i)
      SzByte: begin
        load_o                = {{24{byte_v[7] & ~uns_i}}, byte_v};
        merged_o              = word_i;
        merged_o[byte_sh +: 8] = wdata_i[7:0];
      end
      SzHalf: begin
        load_o                  = {{16{half_v[15] & ~uns_i}}, half_v};
        merged_o                = word_i;
        merged_o[half_sh +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_master.sv
// RAM initiator: turns byte-addressed CPU loads/stores into word RAM cycles,
// with read-modify-write for sub-word stores.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_oe,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e              state_q, state_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                we_q, we_d;
  logic                uns_q, uns_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   lane_load;
  logic [DATA_W-1:0]   lane_merged;
  logic                accept;

  // High address bits wrap onto the RAM.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  assign accept = (state_q == StIdle) && req;

  mem_lane u_lane (
    .word_i   (ram_rdata),
    .wdata_i  (wdata_q),
    .off_i    (addr_q[1:0]),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .load_o   (lane_load),
    .merged_o (lane_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (misaligned(size, addr[1:0])) begin
            state_d = StFault;
          end else if (we && size[1]) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = StCapt;
      StCapt:  state_d = we_q ? StWr : StIdle;
      StWr:    state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ram_cs = 1'b0;
    ram_rd = 1'b0;
    ram_oe = 1'b0;
    case (state_q)
      StRd, StCapt: begin
        ram_cs = 1'b1;
        ram_rd = 1'b1;
        ram_oe = 1'b1;
      end
      StWr:    ram_cs = 1'b1;
      default: ;
    endcase
  end

  // Request capture, result registers and completion flags.
  always_comb begin
    addr_d      = addr_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ram_wdata_d = ram_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    if (accept) begin
      addr_d      = addr[ADDR_W+1:0];
      size_d      = size;
      we_d        = we;
      uns_d       = uns;
      wdata_d     = wdata;
      // Word stores go straight to WR, so the write word is staged here.
      ram_wdata_d = wdata;
    end
    case (state_q)
      StCapt: begin
        if (we_q) begin
          ram_wdata_d = lane_merged;
        end else begin
          rdata_d = lane_load;
          done_d  = 1'b1;
        end
      end
      StWr:    done_d = 1'b1;
      StFault: begin
        done_d = 1'b1;
        err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ram_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ram_wdata_q <= ram_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = state_q != StIdle;
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with a behavioural word RAM.
module tb_ram_master;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          uns;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          done;
  logic          err;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_cs;
  logic          ram_rd;
  logic          ram_oe;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  ram_master #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .size      (size),
    .uns       (uns),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_cs    (ram_cs),
    .ram_rd    (ram_rd),
    .ram_oe    (ram_oe),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Word RAM: writes on cs&~rd, registered read data driven while cs&rd&oe.
  logic [31:0] mem [1024];
  logic [31:0] rd_q;
  logic        mem_clr;
  int          wr_cnt;
  int          cs_cnt;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      rd_q   <= '0;
      wr_cnt <= 0;
      cs_cnt <= 0;
    end else begin
      if (ram_cs && !ram_rd) begin
        mem[ram_addr] <= ram_wdata;
        wr_cnt        <= wr_cnt + 1;
      end
      if (ram_cs && ram_rd && ram_oe) rd_q <= mem[ram_addr];
      if (ram_cs) cs_cnt <= cs_cnt + 1;
    end
  end

  assign ram_rdata = (ram_cs && ram_rd && ram_oe) ? rd_q : 32'h0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Issues one request at the next edge and waits (bounded) for done.
  task automatic do_op(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic e);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!done && lat < 20);
    e = err;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vecs[18];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } b2b_t;

  b2b_t ops[4];

  initial begin
    int   lat;
    logic e;
    int   wr0, cs0, idx, idle_n, cyc;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h010,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1, 1};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h010,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 2, 0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h020,  32'h11223344, 1'b0, 32'h0,        1'b0, 1, 1};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h021,  32'h000000AA, 1'b0, 32'h0,        1'b0, 3, 1};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h020,  32'h0,        1'b1, 32'h11AA3344, 1'b0, 2, 0};
    vecs[5]  = '{1'b1, 2'b10, 1'b0, 32'h030,  32'h80FF7F01, 1'b0, 32'h0,        1'b0, 1, 1};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h030,  32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 2, 0};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 32'h030,  32'h0,        1'b1, 32'h00000080, 1'b0, 2, 0};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h032,  32'h0,        1'b1, 32'h00007F01, 1'b0, 2, 0};
    vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h030,  32'h0,        1'b1, 32'h000080FF, 1'b0, 2, 0};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h033,  32'h0,        1'b1, 32'h00000001, 1'b0, 2, 0};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h042,  32'h0,        1'b1, 32'h00000001, 1'b1, 1, 0};
    vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h045,  32'h0000FFFF, 1'b1, 32'h00000001, 1'b1, 1, 0};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h044,  32'h0,        1'b1, 32'h00000000, 1'b0, 2, 0};
    vecs[14] = '{1'b1, 2'b01, 1'b0, 32'h012,  32'h00001234, 1'b0, 32'h0,        1'b0, 3, 1};
    vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h1010, 32'h0,        1'b1, 32'hDEAD1234, 1'b0, 2, 0};
    vecs[16] = '{1'b0, 2'b01, 1'b0, 32'h030,  32'h0,        1'b1, 32'hFFFF80FF, 1'b0, 2, 0};
    vecs[17] = '{1'b0, 2'b11, 1'b0, 32'h020,  32'h0,        1'b1, 32'h11AA3344, 1'b0, 2, 0};

    ops[0] = '{1'b1, 32'h060, 32'hCAFEF00D, 32'h0};
    ops[1] = '{1'b0, 32'h060, 32'h0,        32'hCAFEF00D};
    ops[2] = '{1'b1, 32'h064, 32'h0BADC0DE, 32'h0};
    ops[3] = '{1'b0, 32'h064, 32'h0,        32'h0BADC0DE};

    req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    rst = 1'b1; mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset rdata", rdata, 32'h0);
    check("reset flags", {29'b0, done, err, busy}, 32'h0);
    check("reset strobes", {29'b0, ram_cs, ram_rd, ram_oe}, 32'h0);
    check("reset ram_wdata", ram_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;

    for (int i = 0; i < 18; i++) begin
      wr0 = wr_cnt;
      cs0 = cs_cnt;
      do_op(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, lat, e);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d ram writes", i), 32'(wr_cnt - wr0), 32'(vecs[i].exp_wr));
      if (vecs[i].chk) check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_err) check($sformatf("v%0d no cs", i), 32'(cs_cnt - cs0), 32'h0);
      @(posedge clk);
      #1 check($sformatf("v%0d done pulse", i), {30'b0, done, err}, 32'h0);
    end

    // Reset while a byte store sits in CAPT: no write may reach the RAM.
    do_op(1'b1, 2'b10, 1'b0, 32'h050, 32'h55667788, lat, e);
    check("rmw-reset setup latency", 32'(lat), 32'd1);
    wr0 = wr_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h051; wdata = 32'h99;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 check("capt read strobes", {29'b0, ram_cs, ram_rd, ram_oe}, 32'h7);
    #2 rst = 1'b1;
    #1;
    check("midop reset flags", {29'b0, done, err, busy}, 32'h0);
    check("midop reset strobes", {29'b0, ram_cs, ram_rd, ram_oe}, 32'h0);
    check("midop reset ram_wdata", ram_wdata, 32'h0);
    check("midop reset rdata", rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midop reset no write", 32'(wr_cnt - wr0), 32'h0);
    do_op(1'b0, 2'b10, 1'b0, 32'h050, 32'h0, lat, e);
    check("post-reset latency", 32'(lat), 32'd2);
    check("post-reset reload", rdata, 32'h55667788);

    // req held high with alternating store/load; next op staged when done is seen.
    @(negedge clk);
    wr0 = wr_cnt; idx = 0; idle_n = 0; cyc = 0;
    req = 1'b1; we = ops[0].we; size = 2'b10; uns = 1'b0;
    addr = ops[0].addr; wdata = ops[0].wdata;
    while (idx < 4 && cyc < 80) begin
      @(posedge clk);
      #1 cyc++;
      if (!busy) idle_n++;
      if (done) begin
        if (!ops[idx].we) check($sformatf("b2b op%0d rdata", idx), rdata, ops[idx].exp);
        idx++;
        if (idx < 4) begin
          we = ops[idx].we; addr = ops[idx].addr; wdata = ops[idx].wdata;
        end else begin
          req = 1'b0;
        end
      end
    end
    check("b2b ops completed", 32'(idx), 32'd4);
    check("b2b total edges", 32'(cyc), 32'd10);
    check("b2b idle cycles", 32'(idle_n), 32'd4);
    check("b2b ram writes", 32'(wr_cnt - wr0), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Initiator for the on-chip word RAM (10-bit word address, cs/rd/oe strobes, 32-bit data).
- Translates byte-addressed CPU load/store requests (byte, half, word; signed or unsigned loads) into RAM cycles.
- Sub-word stores are performed as read-modify-write.
- Sits between the MEM pipeline stage and the RAM; replaces direct RAM strobing by the datapath.

Parameters:
- ADDR_W, 10, RAM word-address width; CPU byte address bits [ADDR_W+1:2] form the word address.
- DATA_W, 32, data width; fixed at 32 (lane logic assumes 4 bytes).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- uns  in  1  load zero-extends when 1, sign-extends when 0
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- rdata  out  32  load result, registered
- done  out  1  one-cycle completion pulse
- err  out  1  misaligned flag, valid with done
- busy  out  1  high whenever state != IDLE
- ram_addr  out  ADDR_W  to RAM addr
- ram_cs  out  1  to RAM cs
- ram_rd  out  1  to RAM rd (1 read, 0 write)
- ram_oe  out  1  to RAM oe
- ram_wdata  out  32  to RAM write_data
- ram_rdata  in  32  from RAM read_data; valid the cycle after a read edge while cs&rd&oe held

Behaviour:
- Reset (async, immediate): state=IDLE; rdata=0, done=0, err=0, busy=0; ram_cs=ram_rd=ram_oe=0, ram_wdata=0. A reset mid-operation aborts it with no RAM write, because cs drops asynchronously.
- Request registers: addr, size, we, uns and wdata are captured on the accepting edge. The RAM port is driven only from these registers.
- Byte lanes are big-endian: addr[1:0]=0 selects bits [31:24]; halfword addr[1]=0 selects [31:16].
- Misaligned requests: a half with addr[0]=1, or a word with addr[1:0]!=0.
  - IDLE goes to FAULT; no RAM strobe is issued.
  - Next edge: done=1, err=1, rdata unchanged.
- Address bits above ADDR_W+1 are ignored (wrap).
- States: IDLE, RD, CAPT, WR, FAULT.
  - IDLE: on req, go to FAULT if misaligned; WR if word store; otherwise RD.
  - RD: cs=1, rd=1, oe=1; always go to CAPT.
  - CAPT: cs=1, rd=1, oe=1 (keeps read_data driven).
    - Load: register the extracted and extended lane into rdata, set done=1, go to IDLE.
    - Sub-word store: merge wdata lane into ram_rdata, register the result into ram_wdata, go to WR.
  - WR: cs=1, rd=0, oe=0, ram_wdata driven; RAM writes at the edge; done=1; go to IDLE.
  - FAULT: done=1, err=1; go to IDLE.
- done and err are high for exactly one cycle; err=0 on all non-fault completions.
- Latency from the accepting edge to done high:
  - word store: 1
  - load: 2
  - sub-word store: 3
  - fault: 1
- req is ignored while busy. req in the same cycle as done (state IDLE next) is accepted on the following edge; back-to-back requests have no dead cycle beyond IDLE.
- Strobes are idle (all 0) in IDLE and FAULT.

Decomposition:
- Shared header mem_defs.v holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state encodings S_IDLE, S_RD, S_CAPT, S_WR, S_FAULT
- One combinational sub-module, mem_lane, takes (word, wdata, addr[1:0], size, uns) and produces extracted load data and the merged store word.
- ram_master holds the FSM, request registers and RAM strobes.

Test Plan:
- Word store 0xDEADBEEF @0x010, then word load @0x010 -> done 1 cycle after the store accept; load done 2 cycles after accept; rdata=0xDEADBEEF, err=0.
- With 0x11223344 @0x020, byte store 0xAA @0x021 -> 3-cycle latency; word load returns 0x11AA3344. Also check exactly one cs&~rd edge occurred.
- With 0x80FF7F01 @0x030, run these loads:
  - signed byte @0x030 -> 0xFFFFFF80
  - unsigned byte @0x030 -> 0x00000080
  - signed half @0x032 -> 0x00007F01
  - unsigned half @0x030 -> 0x000080FF
- Misaligned: word load @0x042, half store @0x045 -> done+err next cycle, no cs assertion, memory unchanged, rdata retains its prior value.
- rst pulsed mid-way during a sub-word store while in CAPT -> all outputs 0 immediately; target word unchanged on reload; next request completes normally.
- req held high continuously with alternating load/store -> each accepted only in IDLE; busy deasserted exactly one cycle between operations; no request lost or duplicated.
